paddle_ctrl: RTL
================

# paddle_ctrl

Parametrised paddle controller for the Breakout playfield. It replaces the fixed-step bar with:
- velocity ramping while a key is held;
- clamp-to-wall positioning instead of refusing moves;
- timed wide/narrow size power-ups with gradual resize.

It sits between the keyboard keycode path and the ball/collision and sprite-drawing logic, and runs once per frame tick.

## Interface
Parameters:
- X_MIN, 10, leftmost legal pixel column
- X_MAX, 639, rightmost legal pixel column
- X_BEGIN, 320, centre X after reset or paddle_reset
- Y_POS, 460, fixed centre Y
- HALF_H, 3, half-height reported on Paddle_Sizey
- HW_NORMAL, 30, normal half-width
- HW_WIDE, 50, wide power-up half-width
- HW_NARROW, 15, narrow power-up half-width
- MAX_STEP, 4, maximum pixels moved per frame
- ACCEL_FRAMES, 8, frames held at one speed before speed increments
- POWER_FRAMES, 600, power-up duration in frames

Ports:
- frame_clk  in  1  frame-rate clock; the only clock
- Reset  in  1  synchronous, active-high; full reset
- Paddle_Reset  in  1  synchronous re-centre between lives/levels
- keycode  in  8  8'h04 = left (A), 8'h07 = right (D); anything else = released
- size_req  in  1  one-frame strobe requesting a size mode
- size_sel  in  2  0 = normal, 1 = wide, 2 = narrow, 3 = ignored
- PaddleX  out  10  centre X
- PaddleY  out  10  constant Y_POS
- Paddle_Sizex  out  10  current half-width
- Paddle_Sizey  out  10  constant HALF_H
- moving  out  1  high while speed ≠ 0
- dir_left  out  1  last movement direction (1 = left)
- power_active  out  1  power-up timer non-zero

## Operation
- State machine with states IDLE, MOVE_L and MOVE_R.
  - IDLE: speed = 0.
  - A key in IDLE or MOVE_R: go to MOVE_L with speed = 1 and acc_cnt = 0.
  - D key: symmetric, goes to MOVE_R.
  - Same key held: acc_cnt increments. When acc_cnt = ACCEL_FRAMES-1 and speed < MAX_STEP: speed += 1 and acc_cnt = 0. At MAX_STEP, acc_cnt saturates.
  - Release or unknown keycode: go to IDLE, speed = 0, acc_cnt = 0.
- Position update, every frame: pos ← clamp(pos ± speed_next, X_MIN+cur_hw, X_MAX−cur_hw), using the speed computed at the same edge.
  - Arithmetic is 12-bit signed internally, so no unsigned wrap at the left edge.
  - Hitting a wall does not change state or speed.
- Size control:
  - size_req with sel 1 or 2: set target_hw and load the timer with POWER_FRAMES.
  - size_req with sel 0: target = HW_NORMAL, timer = 0.
  - size_req with sel 3: ignored.
  - The timer decrements each frame while non-zero. On the 1→0 transition, target reverts to HW_NORMAL.
  - cur_hw steps 1 per frame toward target_hw.
  - Position is re-clamped with the new cur_hw in the same frame, so paddle edges never leave [X_MIN, X_MAX].
- Precedence, highest first: Reset, Paddle_Reset, size_req, timer expiry.
- Paddle_Reset: pos = X_BEGIN, IDLE, speed = 0, cur_hw = target_hw = HW_NORMAL, timer = 0.

## Timing
- All state changes on posedge frame_clk; all outputs are registered.
- Latency: a keycode sampled at edge N shows on PaddleX after edge N.
- Reset values:
  - PaddleX = X_BEGIN, PaddleY = Y_POS
  - Paddle_Sizex = HW_NORMAL, Paddle_Sizey = HALF_H
  - moving = 0, dir_left = 0, power_active = 0
- Reset or Paddle_Reset asserted mid-resize or mid-acceleration takes effect at that edge; no partial update occurs.
- Simultaneous direction reversal and wall clamp: reversal applies and speed = 1 from the clamped position.
- size_req with a new mode while a timer is running: the timer is reloaded and the target retargets from the current cur_hw.

## Structure
- breakout_pkg contains:
  - paddle_state_t enum {IDLE, MOVE_L, MOVE_R}
  - KEY_LEFT = 8'h04, KEY_RIGHT = 8'h07
  - size_sel encodings SIZE_NORMAL / SIZE_WIDE / SIZE_NARROW
- Sub-module paddle_size_ctrl owns target_hw, cur_hw and the power-up timer. It outputs cur_hw and power_active.
- paddle_ctrl owns the movement FSM, acceleration counter and clamp.

## Test plan
- Reset, then hold D for 8 frames → PaddleX 321..328. Frame 9 → 330 (speed 2). moving = 1, dir_left = 0.
- Hold D continuously → speed saturates at 4; PaddleX stops at 609 and remains 609 while D is held.
- At 609 at speed 4, switch to A → 608 next frame (speed 1), dir_left = 1. Release → PaddleX holds, moving = 0.
- At X = 609, size_req with sel = 1 → Paddle_Sizex 31..50 over 20 frames. PaddleX tracks 608..589. power_active = 1.
- After 600 frames → power_active = 0, Paddle_Sizex shrinks 50→30 over 20 frames, PaddleX unchanged.
- Paddle_Reset mid-resize while moving left → next edge: PaddleX = 320, Paddle_Sizex = 30, moving = 0, power_active = 0.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared types and constants for the Breakout paddle logic.
// Contents: paddle FSM state enum, keycodes, size-mode encodings,
//           signed position type and a clamp helper.
package breakout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } paddle_state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;  // A
    localparam logic [7:0] KEY_RIGHT = 8'h07;  // D

    localparam logic [1:0] SIZE_NORMAL = 2'd0;
    localparam logic [1:0] SIZE_WIDE   = 2'd1;
    localparam logic [1:0] SIZE_NARROW = 2'd2;

    // Signed width for position arithmetic so pos - speed never wraps near column 0.
    localparam int POS_W = 12;
    typedef logic signed [POS_W-1:0] pos_t;

    function automatic pos_t clamp_pos(input pos_t v, input pos_t lo, input pos_t hi);
        pos_t r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: key/size requests in, paddle geometry and status out.
// Ports: keycode, size_req, size_sel (requests); PaddleX/Y, Paddle_Sizex/y,
//        moving, dir_left, power_active (status). slave = controller side.
interface paddle_ctrl_if;

    logic [7:0] keycode;
    logic       size_req;
    logic [1:0] size_sel;
    logic [9:0] PaddleX;
    logic [9:0] PaddleY;
    logic [9:0] Paddle_Sizex;
    logic [9:0] Paddle_Sizey;
    logic       moving;
    logic       dir_left;
    logic       power_active;

    modport master (
        output keycode, size_req, size_sel,
        input  PaddleX, PaddleY, Paddle_Sizex, Paddle_Sizey,
        input  moving, dir_left, power_active
    );

    modport slave (
        input  keycode, size_req, size_sel,
        output PaddleX, PaddleY, Paddle_Sizex, Paddle_Sizey,
        output moving, dir_left, power_active
    );

endinterface

// File: rtl/paddle_size_ctrl.sv
// Paddle half-width control: power-up target, 1-px/frame resize and power-up timer.
// Ports: clk_i, rst_i (full reset), paddle_reset_i, size_req_i/size_sel_i in;
//        cur_hw_o (registered), cur_hw_next_o (value loaded at this edge), power_active_o.
module paddle_size_ctrl
    import breakout_pkg::*;
#(
    parameter int HW_NORMAL    = 30,
    parameter int HW_WIDE      = 50,
    parameter int HW_NARROW    = 15,
    parameter int POWER_FRAMES = 600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       paddle_reset_i,
    input  logic       size_req_i,
    input  logic [1:0] size_sel_i,
    output logic [9:0] cur_hw_o,
    output logic [9:0] cur_hw_next_o,
    output logic       power_active_o
);

    localparam int TMR_W = $clog2(POWER_FRAMES + 1);

    localparam logic [9:0]       HW_N     = 10'(HW_NORMAL);
    localparam logic [9:0]       HW_W     = 10'(HW_WIDE);
    localparam logic [9:0]       HW_R     = 10'(HW_NARROW);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POWER_FRAMES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [9:0]       target_q, target_d;
    logic [9:0]       cur_q, cur_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_comb begin
        target_d = target_q;
        timer_d  = timer_q;

        if (rst_i || paddle_reset_i) begin
            target_d = HW_N;
            timer_d  = '0;
        end else if (size_req_i && (size_sel_i != 2'd3)) begin
            // A new request always restarts the timer; resize continues from cur_q.
            case (size_sel_i)
                SIZE_WIDE: begin
                    target_d = HW_W;
                    timer_d  = TMR_LOAD;
                end
                SIZE_NARROW: begin
                    target_d = HW_R;
                    timer_d  = TMR_LOAD;
                end
                default: begin
                    target_d = HW_N;
                    timer_d  = '0;
                end
            endcase
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_ONE;
            if (timer_q == TMR_ONE) begin
                target_d = HW_N;
            end
        end

        // Step toward the target chosen at this same edge.
        if (rst_i || paddle_reset_i) begin
            cur_d = HW_N;
        end else if (cur_q < target_d) begin
            cur_d = cur_q + 10'd1;
        end else if (cur_q > target_d) begin
            cur_d = cur_q - 10'd1;
        end else begin
            cur_d = cur_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            target_q <= HW_N;
            cur_q    <= HW_N;
            timer_q  <= '0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            timer_q  <= timer_d;
        end
    end

    assign cur_hw_o       = cur_q;
    assign cur_hw_next_o  = cur_d;
    assign power_active_o = (timer_q != '0);

endmodule

// File: rtl/paddle_ctrl.sv
// Breakout paddle controller: accelerating movement, wall clamp, timed size power-ups.
// Ports: frame_clk, Reset (full), Paddle_Reset (re-centre) plain; keycode/size
//        requests in and paddle geometry/status out through paddle_ctrl_if.slave.
module paddle_ctrl
    import breakout_pkg::*;
#(
    parameter int X_MIN        = 10,
    parameter int X_MAX        = 639,
    parameter int X_BEGIN      = 320,
    parameter int Y_POS        = 460,
    parameter int HALF_H       = 3,
    parameter int HW_NORMAL    = 30,
    parameter int HW_WIDE      = 50,
    parameter int HW_NARROW    = 15,
    parameter int MAX_STEP     = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int POWER_FRAMES = 600
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         Paddle_Reset,
    paddle_ctrl_if.slave bus
);

    localparam int SPD_W = $clog2(MAX_STEP + 1);
    localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_STEP);
    localparam logic [SPD_W-1:0] SPD_ONE  = SPD_W'(1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
    localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam pos_t             POS_BEGIN = pos_t'(X_BEGIN);

    paddle_state_t    state_q, state_d;
    logic [SPD_W-1:0] speed_q, speed_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    pos_t             pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             moving_q;

    logic [9:0] cur_hw;
    logic [9:0] cur_hw_next;
    logic       power_active;

    logic key_left;
    logic key_right;

    pos_t hw_s;
    pos_t spd_s;
    pos_t pos_mv;

    paddle_size_ctrl #(
        .HW_NORMAL    (HW_NORMAL),
        .HW_WIDE      (HW_WIDE),
        .HW_NARROW    (HW_NARROW),
        .POWER_FRAMES (POWER_FRAMES)
    ) u_size (
        .clk_i          (frame_clk),
        .rst_i          (Reset),
        .paddle_reset_i (Paddle_Reset),
        .size_req_i     (bus.size_req),
        .size_sel_i     (bus.size_sel),
        .cur_hw_o       (cur_hw),
        .cur_hw_next_o  (cur_hw_next),
        .power_active_o (power_active)
    );

    assign key_left  = (bus.keycode == KEY_LEFT);
    assign key_right = (bus.keycode == KEY_RIGHT);

    // Movement FSM: speed ramps by one every ACCEL_FRAMES frames of the same key.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        acc_d   = acc_q;
        dir_d   = dir_q;

        if (key_left || key_right) begin
            if ((key_left && state_q == MOVE_L) || (key_right && state_q == MOVE_R)) begin
                if (acc_q == ACC_LAST) begin
                    // At top speed the counter just parks at its last value.
                    if (speed_q < SPD_MAX) begin
                        speed_d = speed_q + SPD_ONE;
                        acc_d   = '0;
                    end
                end else begin
                    acc_d = acc_q + ACC_ONE;
                end
            end else begin
                state_d = key_left ? MOVE_L : MOVE_R;
                speed_d = SPD_ONE;
                acc_d   = '0;
            end
        end else begin
            state_d = IDLE;
            speed_d = '0;
            acc_d   = '0;
        end

        if (state_d == MOVE_L) begin
            dir_d = 1'b1;
        end else if (state_d == MOVE_R) begin
            dir_d = 1'b0;
        end
    end

    // Clamp against the half-width loaded at this edge, so a resize never
    // pushes a paddle edge past the playfield even when not moving.
    always_comb begin
        hw_s   = pos_t'(cur_hw_next);
        spd_s  = pos_t'(speed_d);
        pos_mv = (state_d == MOVE_L) ? (pos_q - spd_s) : (pos_q + spd_s);
        pos_d  = clamp_pos(pos_mv, pos_t'(X_MIN) + hw_s, pos_t'(X_MAX) - hw_s);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            speed_q  <= '0;
            acc_q    <= '0;
            pos_q    <= POS_BEGIN;
            dir_q    <= 1'b0;
            moving_q <= 1'b0;
        end else if (Paddle_Reset) begin
            // Re-centre only; the last direction is kept.
            state_q  <= IDLE;
            speed_q  <= '0;
            acc_q    <= '0;
            pos_q    <= POS_BEGIN;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            acc_q    <= acc_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            moving_q <= (speed_d != '0);
        end
    end

    // Clamping keeps pos_q within 0..1023, so only the low ten bits are presented.
    logic unused_pos_hi;
    assign unused_pos_hi = ^pos_q[POS_W-1:10];

    assign bus.PaddleX      = pos_q[9:0];
    assign bus.PaddleY      = 10'(Y_POS);
    assign bus.Paddle_Sizex = cur_hw;
    assign bus.Paddle_Sizey = 10'(HALF_H);
    assign bus.moving       = moving_q;
    assign bus.dir_left     = dir_q;
    assign bus.power_active = power_active;

endmodule
